io_uart_tx: RTL
===============

// Module: io_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter. Responder on the core's IO bus (io_addr/io_en/io_we/io_data_*),
//  driven by the MMU as initiator. CPU stores bytes into a FIFO; a shifter serialises them 8N1 on uart_tx.
//  Gives firmware a console output port on the iCE40 board.
// PARAMETERS
//  BASE_ADDR   8'h40    block selected when io_addr[7:4] == BASE_ADDR[7:4]
//  FIFO_DEPTH  4        TX FIFO entries; power of 2, >= 2
//  DIV_RESET   16'd103  reset value of DIVISOR; bit period = DIVISOR+1 clk cycles
// PORTS
//  clk            in   1   core clock; all logic on rising edge
//  reset          in   1   synchronous, active-high reset
//  io_addr        in   8   byte address from MMU; word offset = io_addr[3:2]
//  io_en          in   1   bus access strobe, one cycle per access
//  io_we          in   1   1 = write, 0 = read; qualified by io_en
//  io_data_write  in   32  write data
//  io_data_read   out  32  registered read data; 0 when not responding (OR-combinable)
//  uart_tx        out  1   serial line, idle high
// BEHAVIOUR
//  sel = io_en && io_addr[7:4]==BASE_ADDR[7:4]. Writes commit at the edge where sel && io_we.
//  Read: io_data_read valid the cycle after sel && !io_we, exactly 1 cycle, then returns to 0.
//  Register map (offset io_addr[3:2]):
//   0 TXDATA  W: push io_data_write[7:0]. If FIFO full, byte dropped, OVERRUN set. R: 0.
//   1 STATUS  R: [0] full [1] empty [2] busy (FSM != IDLE) [3] OVERRUN [7:4] FIFO count; rest 0.
//             W: bit3 = 1 clears OVERRUN; other bits ignored.
//   2 DIVISOR R/W [15:0]; upper bits read 0. Latched by the shifter at each frame start;
//             mid-frame writes affect the next frame only.
//   3 reserved: reads 0, writes ignored.
//  Reset: uart_tx=1, io_data_read=0, FIFO empty, OVERRUN=0, DIVISOR=DIV_RESET, FSM=IDLE.
//   Reset mid-frame aborts the frame; uart_tx high the cycle after reset.
//  FIFO full/empty are evaluated before the edge: a push to a full FIFO is dropped even if a pop
//   occurs in the same cycle. Push and pop in the same cycle on a non-full, non-empty FIFO both occur.
//   Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1, saturated at 15 in STATUS.
//  FSM (uart_tx registered; baud counter counts 0..div_latched):
//   IDLE : uart_tx=1. If FIFO non-empty: pop, load shifter, latch DIVISOR, go to START.
//   START: uart_tx=0 for one bit period, then go to DATA with bit_idx=0.
//   DATA : uart_tx=shift[0], LSB first. At period end, shift; after bit_idx 7, go to STOP.
//   STOP : uart_tx=1 for one bit period. At the end, if FIFO non-empty, pop and go directly to START
//          with no idle gap; else go to IDLE.
//  Latency: TXDATA write at edge N into idle empty block -> pop at N+1; uart_tx falls after edge N+1.
//  Frame length = 10*(DIVISOR+1) cycles.
// STRUCTURE
//  Shared header io_map.vh: IO base addresses (UART_BASE), register offsets, STATUS bit indices.
//  FSM state encodings are localparams in this file.
//  Sub-module io_sync_fifo (WIDTH, DEPTH): synchronous FIFO with push/pop/full/empty/count.
//  The FSM, baud counter, shifter, and register decode live in this module.
// TESTING
//  1 DIVISOR=3; write TXDATA=0x55 -> uart_tx low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each,
//    then high 4 cycles; busy=1 for 40 cycles.
//  2 Six back-to-back TXDATA writes 0x41..0x46, depth 4 -> 0x41..0x45 sent back-to-back with no
//    idle gap, 0x46 dropped, STATUS[3]=1; STATUS write 0x8 -> STATUS[3]=0.
//  3 Read STATUS at reset -> io_data_read=0x00000002 exactly one cycle after the strobe,
//    0 on the cycles before and after.
//  4 Write DIVISOR=7 mid-frame (DIVISOR=3) -> current frame keeps 4-cycle bits, next frame uses 8;
//    DIVISOR reads back 0x00000007.
//  5 Accesses at io_addr=0x50 and at offset 3 -> no state change; io_data_read stays 0.
//  6 Assert reset during DATA -> uart_tx=1 next cycle, STATUS=0x2, DIVISOR=103, no further bits sent.

Source files
------------

// File: rtl/io_uart_tx_pkg.sv
// Shared register offsets, STATUS bit positions and FSM state type for the UART transmitter.
package io_uart_tx_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVERRUN = 3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // FIFO occupancy is reported in a 4-bit STATUS field, so larger counts pin at 15.
    function automatic logic [3:0] sat_nibble(input logic [31:0] value);
        return (value > 32'd15) ? 4'hF : value[3:0];
    endfunction

endpackage

// File: rtl/io_uart_tx_fifo.sv
// Synchronous TX byte FIFO. Full/empty are judged on the pre-edge count, so a push
// into a full FIFO is dropped even when a pop happens in the same cycle.
module io_uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core IO bus.
//
// state    | meaning
// TX_IDLE  | line high, waiting for a byte in the FIFO
// TX_START | start bit (low) for one bit period
// TX_DATA  | eight data bits, LSB first, one bit period each
// TX_STOP  | stop bit (high); chains straight into the next frame if data is queued
module io_uart_tx
    import io_uart_tx_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR  = 8'h40,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd103
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  io_addr,
    input  logic        io_en,
    input  logic        io_we,
    input  logic [31:0] io_data_write,
    output logic [31:0] io_data_read,
    output logic        uart_tx
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic        sel;
    logic        bus_wr;
    logic        bus_rd;
    logic [1:0]  reg_off;
    logic [31:0] rd_word;
    logic [15:0] divisor;
    logic        overrun;

    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_rd_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    tx_state_e   state;
    tx_state_e   state_next;
    logic [15:0] baud_cnt;
    logic [15:0] div_latched;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        period_end;
    logic        tx_next;
    logic        busy;

    logic unused_bits;
    assign unused_bits = ^{io_addr[1:0], io_data_write[31:16]};

    assign sel        = io_en && (io_addr[7:4] == BASE_ADDR[7:4]);
    assign reg_off    = io_addr[3:2];
    assign bus_wr     = sel && io_we;
    assign bus_rd     = sel && !io_we;
    assign fifo_push  = bus_wr && (reg_off == REG_TXDATA);
    assign period_end = (baud_cnt == 16'd0);

    io_uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (io_data_write[7:0]),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Read mux for the addressed register; unmapped offsets read zero.
    always_comb begin
        rd_word = '0;
        case (reg_off)
            REG_STATUS: begin
                rd_word[STAT_FULL]    = fifo_full;
                rd_word[STAT_EMPTY]   = fifo_empty;
                rd_word[STAT_BUSY]    = busy;
                rd_word[STAT_OVERRUN] = overrun;
                rd_word[7:4]          = sat_nibble(32'(fifo_count));
            end
            REG_DIVISOR: rd_word[15:0] = divisor;
            default:     rd_word = '0;
        endcase
    end

    // Register writes, sticky overrun flag and the one-cycle registered read response.
    always_ff @(posedge clk) begin
        if (reset) begin
            divisor      <= DIV_RESET;
            overrun      <= 1'b0;
            io_data_read <= '0;
        end else begin
            if (bus_wr && (reg_off == REG_DIVISOR)) begin
                divisor <= io_data_write[15:0];
            end
            if (fifo_push && fifo_full) begin
                overrun <= 1'b1;
            end else if (bus_wr && (reg_off == REG_STATUS) && io_data_write[STAT_OVERRUN]) begin
                overrun <= 1'b0;
            end
            io_data_read <= bus_rd ? rd_word : 32'd0;
        end
    end

    // State register together with the registered serial line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= TX_IDLE;
            uart_tx <= 1'b1;
        end else begin
            state   <= state_next;
            uart_tx <= tx_next;
        end
    end

    // Next-state and FIFO pop decision; STOP pops directly so back-to-back frames have no gap.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        case (state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = TX_START;
                end
            end
            TX_START: begin
                if (period_end) state_next = TX_DATA;
            end
            TX_DATA: begin
                if (period_end && (bit_idx == 3'd7)) state_next = TX_STOP;
            end
            TX_STOP: begin
                if (period_end) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        state_next = TX_START;
                    end else begin
                        state_next = TX_IDLE;
                    end
                end
            end
            default: state_next = TX_IDLE;
        endcase
    end

    // Line level for the coming cycle; inside DATA a period end exposes the next shifted bit.
    always_comb begin
        busy    = (state != TX_IDLE);
        tx_next = 1'b1;
        case (state_next)
            TX_START: tx_next = 1'b0;
            TX_DATA:  tx_next = ((state == TX_DATA) && period_end) ? shift[1] : shift[0];
            default:  tx_next = 1'b1;
        endcase
    end

    // Baud down-counter, bit index and shifter; the divisor is captured once per frame at pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt    <= '0;
            div_latched <= DIV_RESET;
            bit_idx     <= '0;
            shift       <= '0;
        end else if (fifo_pop) begin
            shift       <= fifo_rd_data;
            div_latched <= divisor;
            baud_cnt    <= divisor;
            bit_idx     <= '0;
        end else if (state != TX_IDLE) begin
            if (period_end) begin
                baud_cnt <= div_latched;
                if (state == TX_DATA) begin
                    shift   <= {1'b0, shift[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                end
            end else begin
                baud_cnt <= baud_cnt - 16'd1;
            end
        end
    end

endmodule
